// File: rtl/ramfifo_ctrl.sv
// FIFO sequencer around a single-port synchronous RAM. Optional synchronous
// flush input 'clr' is enabled by defining RAMFIFO_CLEAR_EN.
module ramfifo_ctrl #(
    parameter int AW = 3,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rstn,
`ifdef RAMFIFO_CLEAR_EN
    input  logic          clr,
`endif
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rw,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   DEPTH   = CNT_ONE << AW;

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          prio;
    logic          clr_hit;
    logic          rd_req;
    logic          rd_grant;
    logic          wr_grant;

`ifdef RAMFIFO_CLEAR_EN
    assign clr_hit = clr;
`else
    assign clr_hit = 1'b0;
`endif

    assign full  = (count == DEPTH);
    assign empty = (count == '0);

    // A read may only be issued when the output register is free, so at most
    // one word is ever in flight between the RAM and out_data.
    assign rd_req   = (state == IDLE) && !empty && !out_valid;
    assign in_ready = rstn && !clr_hit && !full && !(rd_req && prio);
    assign wr_grant = in_ready && in_valid;
    assign rd_grant = rd_req && (!in_valid || prio) && !clr_hit;

    assign ram_wdata = in_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ram_rw    = 1'b1;
        ram_addr  = rd_ptr;
        case (state)
            IDLE:    if (rd_grant) state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (wr_grant) begin
            ram_rw   = 1'b0;
            ram_addr = wr_ptr;
        end
        if (clr_hit) begin
            state_nxt = IDLE;
        end
    end

    // Grants are mutually exclusive, so count moves by at most one per edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            prio      <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (clr_hit) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            prio      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (wr_grant) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                count  <= count + CNT_ONE;
                prio   <= 1'b1;
            end else if (rd_grant) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                count  <= count - CNT_ONE;
                prio   <= 1'b0;
            end
            if (state == RD_WAIT) begin
                out_data  <= ram_rdata;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ramfifo_ctrl.sv
// Directed bench for ramfifo_ctrl with a behavioural single-port RAM model.
module tb_ramfifo_ctrl;

    localparam int AW = 3;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
`ifdef RAMFIFO_CLEAR_EN
    logic          clr = 1'b0;
`endif
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] ram_addr;
    logic          ram_rw;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;
    logic [AW:0]   count;
    logic          full;
    logic          empty;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            resetWrites = 0;
    int            tests = 0;
    int            fails = 0;

    typedef struct {
        logic          iv;
        logic [DW-1:0] din;
        logic          ordy;
        logic          eIr;
        logic          eRw;
        logic [AW-1:0] eAddr;
        logic [AW:0]   eCnt;
        logic          eOv;
        logic [DW-1:0] eOd;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    ramfifo_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk(clk),
        .rstn(rstn),
`ifdef RAMFIFO_CLEAR_EN
        .clr(clr),
`endif
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ram_addr(ram_addr),
        .ram_rw(ram_rw),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata),
        .count(count),
        .full(full),
        .empty(empty)
    );

    // Single-port RAM: write when rw=0 (data_out held), registered read when rw=1.
    always @(posedge clk) begin
        if (!ram_rw) mem[ram_addr] <= ram_wdata;
        else         ram_rdata <= mem[ram_addr];
        if (!rstn && !ram_rw) resetWrites <= resetWrites + 1;
    end

    function automatic void addVec(logic iv, logic [DW-1:0] din, logic ordy,
                                   logic eIr, logic eRw, logic [AW-1:0] eAddr,
                                   logic [AW:0] eCnt, logic eOv, logic [DW-1:0] eOd);
        vec_t v;
        v.iv = iv; v.din = din; v.ordy = ordy;
        v.eIr = eIr; v.eRw = eRw; v.eAddr = eAddr;
        v.eCnt = eCnt; v.eOv = eOv; v.eOd = eOd;
        vecs.push_back(v);
    endfunction

    task automatic checkVal(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        in_valid  = v.iv;
        in_data   = v.din;
        out_ready = v.ordy;
        #1;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        checkVal($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(v.eIr));
        checkVal($sformatf("v%0d ram_rw", idx), 32'(ram_rw), 32'(v.eRw));
        checkVal($sformatf("v%0d ram_addr", idx), 32'(ram_addr), 32'(v.eAddr));
        checkVal($sformatf("v%0d count", idx), 32'(count), 32'(v.eCnt));
        checkVal($sformatf("v%0d full", idx), 32'(full), 32'(v.eCnt == 4'd8));
        checkVal($sformatf("v%0d empty", idx), 32'(empty), 32'(v.eCnt == 4'd0));
        checkVal($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'(v.eOv));
        checkVal($sformatf("v%0d out_data", idx), 32'(out_data), 32'(v.eOd));
        if (!v.eRw)
            checkVal($sformatf("v%0d ram_wdata", idx), 32'(ram_wdata), 32'(v.din));
    endtask

    task automatic runVectors(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end
    endtask

    task automatic expectOut(input string nm, input logic [DW-1:0] exp);
        logic          found;
        logic [DW-1:0] data;
        found = 1'b0;
        data  = '0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                found = 1'b1;
                data  = out_data;
                break;
            end
        end
        checkVal({nm, " out_valid seen"}, 32'(found), 32'd1);
        checkVal({nm, " out_data"}, 32'(data), 32'(exp));
    endtask

    task automatic resetDut();
        @(negedge clk);
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] drainWords [7];

        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

        // Fill with out_ready low: first word reaches out_data, then 8 more fill the RAM.
        addVec(1, 16'h1111, 0, 1, 0, 3'd0, 4'd0, 0, 16'h0000);
        addVec(1, 16'h2222, 0, 0, 1, 3'd0, 4'd1, 0, 16'h0000);
        addVec(1, 16'h2222, 0, 1, 0, 3'd1, 4'd0, 0, 16'h0000);
        addVec(1, 16'h3333, 0, 1, 0, 3'd2, 4'd1, 1, 16'h1111);
        addVec(1, 16'h4444, 0, 1, 0, 3'd3, 4'd2, 1, 16'h1111);
        addVec(1, 16'h5555, 0, 1, 0, 3'd4, 4'd3, 1, 16'h1111);
        addVec(1, 16'h6666, 0, 1, 0, 3'd5, 4'd4, 1, 16'h1111);
        addVec(1, 16'h7777, 0, 1, 0, 3'd6, 4'd5, 1, 16'h1111);
        addVec(1, 16'h8888, 0, 1, 0, 3'd7, 4'd6, 1, 16'h1111);
        addVec(1, 16'h9999, 0, 1, 0, 3'd0, 4'd7, 1, 16'h1111);
        addVec(1, 16'hAAAA, 0, 0, 1, 3'd1, 4'd8, 1, 16'h1111);
        addVec(1, 16'hAAAA, 0, 0, 1, 3'd1, 4'd8, 1, 16'h1111);
        // Start draining from full; 0xAAAA slips in once a slot frees.
        addVec(1, 16'hAAAA, 1, 0, 1, 3'd1, 4'd8, 1, 16'h1111);
        addVec(1, 16'hAAAA, 1, 0, 1, 3'd1, 4'd8, 0, 16'h1111);
        addVec(1, 16'hAAAA, 1, 1, 0, 3'd1, 4'd7, 0, 16'h1111);
        addVec(0, 16'h0000, 1, 0, 1, 3'd2, 4'd8, 1, 16'h2222);
        addVec(0, 16'h0000, 1, 0, 1, 3'd2, 4'd8, 0, 16'h2222);
        addVec(0, 16'h0000, 1, 1, 1, 3'd3, 4'd7, 0, 16'h2222);
        addVec(0, 16'h0000, 1, 1, 1, 3'd3, 4'd7, 1, 16'h3333);
        // Contention: rows 27/28 show write then read with in_ready 1 then 0.
        addVec(1, 16'hB001, 0, 1, 0, 3'd0, 4'd0, 0, 16'h0000);
        addVec(1, 16'hB002, 0, 0, 1, 3'd0, 4'd1, 0, 16'h0000);
        addVec(1, 16'hB002, 0, 1, 0, 3'd1, 4'd0, 0, 16'h0000);
        addVec(1, 16'hB003, 0, 1, 0, 3'd2, 4'd1, 1, 16'hB001);
        addVec(0, 16'h0000, 1, 1, 1, 3'd1, 4'd2, 1, 16'hB001);
        addVec(0, 16'h0000, 0, 0, 1, 3'd1, 4'd2, 0, 16'hB001);
        addVec(0, 16'h0000, 0, 1, 1, 3'd2, 4'd1, 0, 16'hB001);
        addVec(0, 16'h0000, 1, 1, 1, 3'd2, 4'd1, 1, 16'hB002);
        addVec(1, 16'hB004, 0, 1, 0, 3'd3, 4'd1, 0, 16'hB002);
        addVec(1, 16'hB005, 0, 0, 1, 3'd2, 4'd2, 0, 16'hB002);
        addVec(1, 16'hB005, 0, 1, 0, 3'd4, 4'd1, 0, 16'hB002);
        addVec(0, 16'h0000, 1, 1, 1, 3'd3, 4'd2, 1, 16'hB003);

        drainWords = '{16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h9999, 16'hAAAA};

        // Reset values, with in_valid high to show in_ready is forced low.
        repeat (2) @(negedge clk);
        in_valid = 1'b1;
        #1;
        checkVal("rst ram_rw", 32'(ram_rw), 32'd1);
        checkVal("rst in_ready", 32'(in_ready), 32'd0);
        checkVal("rst out_valid", 32'(out_valid), 32'd0);
        checkVal("rst count", 32'(count), 32'd0);
        checkVal("rst empty", 32'(empty), 32'd1);
        checkVal("rst full", 32'(full), 32'd0);
        checkVal("rst ram_addr", 32'(ram_addr), 32'd0);
        checkVal("rst out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rstn     = 1'b1;
        #1;
        checkVal("release in_ready", 32'(in_ready), 32'd1);
        checkVal("rst ram writes", 32'(resetWrites), 32'd0);

        runVectors(0, 18);
        for (int i = 0; i < 7; i++)
            expectOut($sformatf("drain%0d", i), drainWords[i]);
        @(negedge clk);
        #1;
        checkVal("drained count", 32'(count), 32'd0);
        checkVal("drained empty", 32'(empty), 32'd1);
        checkVal("drained out_valid", 32'(out_valid), 32'd0);

        resetDut();
        runVectors(19, 30);
        expectOut("contention B004", 16'hB004);
        expectOut("contention B005", 16'hB005);

        // Reset asserted while a read is in RD_WAIT.
        resetDut();
        resetWrites = 0;
        in_valid = 1'b1;
        in_data  = 16'hC0DE;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rstn     = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        #1;
        checkVal("midrst out_valid", 32'(out_valid), 32'd0);
        checkVal("midrst count", 32'(count), 32'd0);
        checkVal("midrst in_ready", 32'(in_ready), 32'd0);
        checkVal("midrst ram_rw", 32'(ram_rw), 32'd1);
        @(negedge clk);
        #1;
        checkVal("midrst hold out_valid", 32'(out_valid), 32'd0);
        checkVal("midrst ram writes", 32'(resetWrites), 32'd0);
        rstn    = 1'b1;
        in_data = 16'h5A5A;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        expectOut("midrst first", 16'h5A5A);

`ifdef RAMFIFO_CLEAR_EN
        resetDut();
        in_valid = 1'b1;
        in_data  = 16'hD001;
        @(negedge clk);
        in_data = 16'hD002;
        @(negedge clk);
        @(negedge clk);
        in_data = 16'hD003;
        @(negedge clk);
        clr     = 1'b1;
        in_data = 16'h0F0F;
        #1;
        checkVal("clr in_ready", 32'(in_ready), 32'd0);
        checkVal("clr ram_rw", 32'(ram_rw), 32'd1);
        @(negedge clk);
        clr = 1'b0;
        #1;
        checkVal("clr count", 32'(count), 32'd0);
        checkVal("clr out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        expectOut("clr first", 16'h0F0F);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ramfifo_ctrl.md
# ramfifo_ctrl

Sequencing controller that wraps the team's single-port synchronous RAM (`rw`=1 read, `rw`=0 write, registered read data one cycle later) as a FIFO. It sits directly upstream of the RAM. It turns a valid/ready input word stream into RAM writes, and turns RAM reads into a valid/ready output stream for the transmit side. It arbitrates the single RAM port, tracks occupancy, and holds the read word in an output register.

## Interface
- `AW`, 3, RAM address width; depth = 2**AW words
- `DW`, 16, data word width
- `clk`  in  1  global clock, all state on rising edge
- `rstn`  in  1  asynchronous active-low reset
- `in_data`  in  DW  word to store
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  word accepted on edge where `in_valid`&&`in_ready`
- `out_data`  out  DW  registered output word
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  consumer takes word on edge where `out_valid`&&`out_ready`
- `ram_addr`  out  AW  to RAM `addr`
- `ram_rw`  out  1  to RAM `rw`; 0 only in a write-grant cycle
- `ram_wdata`  out  DW  to RAM `data_in` (= `in_data`)
- `ram_rdata`  in  DW  from RAM `data_out`
- `count`  out  AW+1  words stored in RAM, not yet read
- `full`  out  1  `count`==2**AW
- `empty`  out  1  `count`==0

## Operation
- Registers: `wr_ptr`, `rd_ptr` (AW bits, wrap modulo 2**AW), `count`, `prio` (0 = write favoured), FSM `state`, `out_data`, `out_valid`.
- FSM states:
  - IDLE: read issue allowed.
  - RD_WAIT: RAM read data arrives this cycle; always returns to IDLE next edge.
- Request signals:
  - `wr_req` = `in_valid` && !`full`.
  - `rd_req` = (`state`==IDLE) && !`empty` && !`out_valid`.
- Read grant: `rd_req` && (!`in_valid` || `prio`==1).
  - Drive `ram_rw`=1, `ram_addr`=`rd_ptr`.
  - At the edge: `rd_ptr`++, `count`--, `state`<=RD_WAIT, `prio`<=0.
- Write grant: `in_ready` && `in_valid`, where `in_ready` = !`full` && !(`rd_req` && `prio`==1).
  - `in_ready` never depends on `in_valid`.
  - Drive `ram_rw`=0, `ram_addr`=`wr_ptr`, `ram_wdata`=`in_data`.
  - At the edge: `wr_ptr`++, `count`++, `prio`<=1.
- No grant: `ram_rw`=1, `ram_addr`=`rd_ptr` (harmless read).
- Writes are permitted in RD_WAIT. The RAM holds `data_out` when `rw`=0, so `ram_rdata` stays valid.
- RD_WAIT edge: `out_data`<=`ram_rdata`, `out_valid`<=1.
- Output handshake edge with no load: `out_valid`<=0.
- Single port: simultaneous write and read grant is impossible, so `count` changes by at most ±1 per edge.
- Full: `in_ready`=0. Empty: no read issue. A word in the output register is not counted.

## Timing
- Reset (`rstn` low, async): `count`=0, `wr_ptr`=`rd_ptr`=0, `prio`=0, `state`=IDLE, `out_valid`=0, `out_data`=0, `ram_rw`=1, `ram_addr`=0, `in_ready`=0 (forced while `rstn` low), `empty`=1, `full`=0.
- Reset mid-operation: in-flight read and all stored words are discarded; no RAM write occurs during reset.
- Latency (FIFO empty, output register empty): word accepted at edge N; read issued in the cycle after N, ends at edge N+1; `out_valid`=1 after edge N+2.
- Output throughput: at most one word per 3 cycles (issue, RD_WAIT, output handshake).
- Contention (both requesting in IDLE): grants alternate write/read.
- Order is strictly preserved across pointer wrap.

## Configuration
- `RAMFIFO_CLEAR_EN` defined:
  - Adds input `clr` (1 bit, synchronous, active-high).
  - On an edge with `clr`=1: pointers, `count`, `prio`, `out_valid` go to reset values and `state`<=IDLE.
  - `ram_rw`=1 and `in_ready`=0 during the `clr` cycle.
  - `clr` overrides any grant.
- Not defined: no `clr` port; only `rstn` empties the FIFO.

## Test plan
- Hold `rstn`=0 -> `ram_rw`=1, `in_ready`=0, `out_valid`=0, `count`=0, `empty`=1; release -> `in_ready`=1.
- `out_ready`=0, offer 0x1111,0x2222,…,0x9999, then 0xAAAA -> first word lands in `out_data`=0x1111. After 9 accepted words `count`=8, `full`=1, `in_ready`=0, and 0xAAAA is held off.
- From full, set `out_ready`=1 -> `out_data` yields 0x1111…0x9999 in order (pointer wrap exercised), then 0xAAAA. Finally `empty`=1, `count`=0.
- Continuous `in_valid` with a read pending -> `ram_rw` alternates 0,1 while `rd_req` holds. `in_ready` is 0 exactly in the read-grant cycles.
- Assert `rstn`=0 during RD_WAIT -> `out_valid` stays 0, `count`=0. The next written word 0x5A5A is the first output.
- With `RAMFIFO_CLEAR_EN`: write 3 words, pulse `clr` -> `count`=0, `out_valid`=0; next word 0x0F0F comes out first.
